// File: rtl/gbus_wr_initiator_if.sv
// Command, write-data and global-bus write signals of the gbus write initiator.
// The initiator uses "master" (it masters the global bus); its environment uses "slave".
interface gbus_wr_initiator_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CMEM_AW    = 13,
  parameter int CORE_AW    = 4,
  parameter int BIAS_W     = 2
);
  // Handshakes: a transfer happens in every cycle where valid and ready are both
  // high at the rising edge; valid never waits on ready, ready may depend on state.
  logic                              cmd_vld;
  logic                              cmd_rdy;
  logic [CORE_AW-1:0]                cmd_core;
  logic [CMEM_AW-1:0]                cmd_addr;
  logic [CMEM_AW:0]                  cmd_len;
  logic [DATA_WIDTH-1:0]             din;
  logic                              din_vld;
  logic                              din_rdy;
  logic [BIAS_W+CORE_AW+CMEM_AW-1:0] gbus_addr;
  logic                              gbus_wen;
  logic [DATA_WIDTH-1:0]             gbus_wdata;

  modport master (
    input  cmd_vld, cmd_core, cmd_addr, cmd_len, din, din_vld,
    output cmd_rdy, din_rdy, gbus_addr, gbus_wen, gbus_wdata
  );

  modport slave (
    output cmd_vld, cmd_core, cmd_addr, cmd_len, din, din_vld,
    input  cmd_rdy, din_rdy, gbus_addr, gbus_wen, gbus_wdata
  );
endinterface

// File: rtl/gbus_wr_initiator.sv
// Turns a {core, addr, len} command plus a data stream into registered
// global-bus writes to consecutive core-memory words.
module gbus_wr_initiator #(
  parameter int DATA_WIDTH = 64,
  parameter int CMEM_AW    = 13,
  parameter int CORE_AW    = 4,
  parameter int BIAS_W     = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  gbus_wr_initiator_if.master    bus,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   state_dbg
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam int GA_W = BIAS_W + CORE_AW + CMEM_AW;

  state_t                state;
  state_t                state_nxt;
  logic [CORE_AW-1:0]    core_q;
  logic [CMEM_AW-1:0]    addr_q;
  logic [CMEM_AW:0]      rem_q;
  logic                  wen_q;
  logic [GA_W-1:0]       gaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  done_q;
  logic                  err_q;

  logic cmd_fire;
  logic din_fire;
  logic len_zero;
  logic last_word;

  assign bus.cmd_rdy = (state == IDLE);
  // Abort blocks the data handshake in the same cycle, so it wins over din_vld.
  assign bus.din_rdy = (state == BURST) && !abort;

  assign cmd_fire  = bus.cmd_vld && bus.cmd_rdy;
  assign din_fire  = bus.din_vld && bus.din_rdy;
  assign len_zero  = (bus.cmd_len == '0);
  assign last_word = (rem_q == (CMEM_AW+1)'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_fire && !len_zero) state_nxt = BURST;
      end
      BURST: begin
        if (abort)                       state_nxt = IDLE;
        else if (din_fire && last_word)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      core_q  <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      wen_q   <= 1'b0;
      gaddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wen_q  <= din_fire;
      done_q <= din_fire && last_word;
      err_q  <= cmd_fire && len_zero;

      if (cmd_fire && !len_zero) begin
        core_q <= bus.cmd_core;
        addr_q <= bus.cmd_addr;
        rem_q  <= bus.cmd_len;
      end else if (state == BURST && abort) begin
        rem_q  <= '0;
      end else if (din_fire) begin
        // Address wraps naturally at 2^CMEM_AW; the core field is never touched.
        gaddr_q <= {{BIAS_W{1'b0}}, core_q, addr_q};
        wdata_q <= bus.din;
        addr_q  <= addr_q + 1'b1;
        rem_q   <= rem_q - 1'b1;
      end
    end
  end

  assign bus.gbus_wen   = wen_q;
  assign bus.gbus_addr  = gaddr_q;
  assign bus.gbus_wdata = wdata_q;
  assign done           = done_q;
  assign err            = err_q;
  assign busy           = (state == BURST) || wen_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_gbus_wr_initiator.sv
// Directed, table-driven bench for gbus_wr_initiator: one table row per clock
// cycle, plus hand-written reset sequences.
module tb_gbus_wr_initiator;

  localparam int DW = 64;
  localparam int AW = 13;
  localparam int CW = 4;
  localparam int BW = 2;
  localparam int GW = BW + CW + AW;

  logic clk;
  logic rstn;
  logic abort;
  logic busy;
  logic done;
  logic err;
  logic state_dbg;

  int tests;
  int fails;

  gbus_wr_initiator_if #(.DATA_WIDTH(DW), .CMEM_AW(AW), .CORE_AW(CW), .BIAS_W(BW)) bus ();

  gbus_wr_initiator #(.DATA_WIDTH(DW), .CMEM_AW(AW), .CORE_AW(CW), .BIAS_W(BW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          cv;
    logic [CW-1:0] core;
    logic [AW-1:0] addr;
    logic [AW:0]   len;
    logic          dv;
    logic [DW-1:0] d;
    logic          ab;
    logic          e_crdy;
    logic          e_drdy;
    logic          e_wen;
    logic [GW-1:0] e_addr;
    logic          e_done;
    logic          e_err;
    logic          e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic cv, logic [CW-1:0] core, logic [AW-1:0] addr,
                              logic [AW:0] len, logic dv, logic [DW-1:0] d, logic ab,
                              logic e_crdy, logic e_drdy, logic e_wen, logic [GW-1:0] e_addr,
                              logic e_done, logic e_err, logic e_busy);
    vec_t v;
    v.cv = cv; v.core = core; v.addr = addr; v.len = len;
    v.dv = dv; v.d = d; v.ab = ab;
    v.e_crdy = e_crdy; v.e_drdy = e_drdy; v.e_wen = e_wen; v.e_addr = e_addr;
    v.e_done = e_done; v.e_err = e_err; v.e_busy = e_busy;
    return v;
  endfunction

  function automatic logic [DW-1:0] dat(int i);
    return 64'hDA7A_5EED_0000_0000 | 64'(i);
  endfunction

  task automatic chk(string name, int row, logic [DW-1:0] act, logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    bus.cmd_vld = 1'b0; bus.cmd_core = '0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.din_vld = 1'b0; bus.din = '0; abort = 1'b0;
  endtask

  task automatic drive_vec(vec_t v);
    bus.cmd_vld = v.cv; bus.cmd_core = v.core; bus.cmd_addr = v.addr; bus.cmd_len = v.len;
    bus.din_vld = v.dv; bus.din = v.d; abort = v.ab;
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_cmd_rdy"}, -1, 64'(bus.cmd_rdy), 64'd1);
    chk({tag, "_din_rdy"}, -1, 64'(bus.din_rdy), 64'd0);
    chk({tag, "_wen"},     -1, 64'(bus.gbus_wen), 64'd0);
    chk({tag, "_addr"},    -1, 64'(bus.gbus_addr), 64'd0);
    chk({tag, "_wdata"},   -1, bus.gbus_wdata, 64'd0);
    chk({tag, "_busy"},    -1, 64'(busy), 64'd0);
    chk({tag, "_done"},    -1, 64'(done), 64'd0);
    chk({tag, "_err"},     -1, 64'(err), 64'd0);
    chk({tag, "_state"},   -1, 64'(state_dbg), 64'd0);
  endtask

  initial begin
    logic [GW-1:0] last_addr;
    logic [DW-1:0] last_data;
    tests = 0;
    fails = 0;

    // S1: core 3, addr 0x10, len 4, data every cycle
    tbl.push_back(mk(1, 3, 'h10, 4, 0, 0,      0, 1, 0, 0, 0,        0, 0, 1));
    tbl.push_back(mk(0, 0, 0,    0, 1, dat(0), 0, 0, 1, 1, 'h06010,  0, 0, 1));
    tbl.push_back(mk(0, 0, 0,    0, 1, dat(1), 0, 0, 1, 1, 'h06011,  0, 0, 1));
    tbl.push_back(mk(0, 0, 0,    0, 1, dat(2), 0, 0, 1, 1, 'h06012,  0, 0, 1));
    tbl.push_back(mk(0, 0, 0,    0, 1, dat(3), 0, 0, 1, 1, 'h06013,  1, 0, 1));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,      0, 1, 0, 0, 0,        0, 0, 0));
    // S2: address wrap, core 1
    tbl.push_back(mk(1, 1, 'h1FFE, 3, 0, 0,     0, 1, 0, 0, 0,       0, 0, 1));
    tbl.push_back(mk(0, 0, 0,      0, 1, dat(4), 0, 0, 1, 1, 'h03FFE, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,      0, 1, dat(5), 0, 0, 1, 1, 'h03FFF, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,      0, 1, dat(6), 0, 0, 1, 1, 'h02000, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0,      0, 0, 0,      0, 1, 0, 0, 0,       0, 0, 0));
    // S3: len 0 -> err pulse only, data offered but never taken
    tbl.push_back(mk(1, 2, 'h5, 0, 0, 0,      0, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0,   0, 1, dat(7), 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,   0, 0, 0,      0, 1, 0, 0, 0, 0, 0, 0));
    // S4: din_vld toggling, core 2, addr 0x100
    tbl.push_back(mk(1, 2, 'h100, 4, 0, 0,       0, 1, 0, 0, 0,       0, 0, 1));
    tbl.push_back(mk(0, 0, 0,     0, 1, dat(8),  0, 0, 1, 1, 'h04100, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,       0, 0, 1, 0, 0,       0, 0, 1));
    tbl.push_back(mk(0, 0, 0,     0, 1, dat(9),  0, 0, 1, 1, 'h04101, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,       0, 0, 1, 0, 0,       0, 0, 1));
    tbl.push_back(mk(0, 0, 0,     0, 1, dat(10), 0, 0, 1, 1, 'h04102, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,       0, 0, 1, 0, 0,       0, 0, 1));
    tbl.push_back(mk(0, 0, 0,     0, 1, dat(11), 0, 0, 1, 1, 'h04103, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,       0, 1, 0, 0, 0,       0, 0, 0));
    // S5: len 8 aborted after 3 words (abort beats din_vld), then abort ignored in IDLE
    tbl.push_back(mk(1, 4, 'h20, 8, 0, 0,       0, 1, 0, 0, 0,       0, 0, 1));
    tbl.push_back(mk(0, 0, 0,    0, 1, dat(12), 0, 0, 1, 1, 'h08020, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,    0, 1, dat(13), 0, 0, 1, 1, 'h08021, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,    0, 1, dat(14), 0, 0, 1, 1, 'h08022, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,    0, 1, dat(15), 1, 0, 0, 0, 0,       0, 0, 0));
    tbl.push_back(mk(1, 6, 0,    1, 0, 0,       1, 1, 0, 0, 0,       0, 0, 1));
    tbl.push_back(mk(0, 0, 0,    0, 1, dat(16), 0, 0, 1, 1, 'h0C000, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,       0, 1, 0, 0, 0,       0, 0, 0));
    // S6: back-to-back, core 0 then core 5; second cmd while last write is on the bus
    tbl.push_back(mk(1, 0, 'h40, 2, 0, 0,       0, 1, 0, 0, 0,       0, 0, 1));
    tbl.push_back(mk(0, 0, 0,    0, 1, dat(17), 0, 0, 1, 1, 'h00040, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,    0, 1, dat(18), 0, 0, 1, 1, 'h00041, 1, 0, 1));
    tbl.push_back(mk(1, 5, 'h7,  2, 1, dat(19), 0, 1, 0, 0, 0,       0, 0, 1));
    tbl.push_back(mk(0, 0, 0,    0, 1, dat(20), 0, 0, 1, 1, 'h0A007, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,    0, 1, dat(21), 0, 0, 1, 1, 'h0A008, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,       0, 1, 0, 0, 0,       0, 0, 0));

    // reset state
    rstn = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;

    // table: drive at negedge, check readies before the edge, registered outputs after
    last_addr = '0;
    last_data = '0;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive_vec(tbl[i]);
      #1;
      chk("cmd_rdy", i, 64'(bus.cmd_rdy), 64'(tbl[i].e_crdy));
      chk("din_rdy", i, 64'(bus.din_rdy), 64'(tbl[i].e_drdy));
      @(posedge clk);
      #1;
      if (tbl[i].e_wen) begin
        last_addr = tbl[i].e_addr;
        last_data = tbl[i].d;
      end
      chk("gbus_wen",   i, 64'(bus.gbus_wen), 64'(tbl[i].e_wen));
      chk("gbus_addr",  i, 64'(bus.gbus_addr), 64'(last_addr));
      chk("gbus_wdata", i, bus.gbus_wdata, last_data);
      chk("done",       i, 64'(done), 64'(tbl[i].e_done));
      chk("err",        i, 64'(err), 64'(tbl[i].e_err));
      chk("busy",       i, 64'(busy), 64'(tbl[i].e_busy));
    end

    // mid-burst reset: burst is dropped and nothing is written afterwards
    @(negedge clk);
    bus.cmd_vld = 1'b1; bus.cmd_core = 4'd7; bus.cmd_addr = 13'h3; bus.cmd_len = 14'd4;
    @(negedge clk);
    bus.cmd_vld = 1'b0;
    bus.din_vld = 1'b1; bus.din = dat(30);
    @(posedge clk);
    #1;
    chk("mid_wen_before_rst", -1, 64'(bus.gbus_wen), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_wen", k, 64'(bus.gbus_wen), 64'd0);
      chk("post_rst_state",  k, 64'(state_dbg), 64'd0);
    end
    @(negedge clk);
    drive_idle();
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
